// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: ADD/SLL/AND/NEQ/SLT/SUB with registered result and zero flag, valid/ready on both sides.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel-shift SLL; by default SLL shifts one bit per cycle.
module alu_exec_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NEQ = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              valid_q, valid_d;
    logic              accept;
`ifndef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_shl;
`endif

    // Single-cycle ops; in the iterative build SLL only reaches here with shamt == 0.
    function automatic logic [XLEN-1:0] alu_eval(
        input logic [2:0]      ctrl,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (ctrl)
            OP_ADD:  r = a + b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  r = a << b[SHAMT_W-1:0];
`else
            OP_SLL:  r = a;
`endif
            OP_AND:  r = a & b;
            OP_NEQ:  r = XLEN'(a != b);
            OP_SLT:  r = XLEN'($signed(a) < $signed(b));
            OP_SUB:  r = a - b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

`ifndef ALU_FAST_SHIFT_EN
    assign acc_shl = acc_q << 1;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
`ifndef ALU_FAST_SHIFT_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                acc_d = acc_shl;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = HOLD;
                    result_d = acc_shl;
                    zero_d   = (acc_shl == '0);
                    valid_d  = 1'b1;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if ((alu_ctrl == OP_SLL) && (op_b[SHAMT_W-1:0] != '0)) begin
                state_d = SHIFT;
                acc_d   = op_a;
                cnt_d   = op_b[SHAMT_W-1:0];
                valid_d = 1'b0;
            end else
`endif
            begin
                state_d  = HOLD;
                result_d = alu_eval(alu_ctrl, op_a, op_b);
                zero_d   = (alu_eval(alu_ctrl, op_a, op_b) == '0);
                valid_d  = 1'b1;
            end
        end

        // Flush discards anything in flight, including an op accepted on this edge.
        if (flush) begin
            state_d  = IDLE;
            result_d = '0;
            zero_d   = 1'b0;
            valid_d  = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            acc_d    = '0;
            cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
`ifndef ALU_FAST_SHIFT_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; honours ALU_FAST_SHIFT_EN for SLL timing.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int tests  = 0;
    int failed = 0;

    alu_exec_stage #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        tests++; if (result !== 32'd0) begin failed++; $display("FAIL rst_result: got %h want 0", result); end
        tests++; if (zero !== 1'b0) begin failed++; $display("FAIL rst_zero: got %b want 0", zero); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_sub();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'd5, 32'd7);
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL add_valid: got %b want 1", out_valid); end
        tests++; if (result !== 32'd12) begin failed++; $display("FAIL add_result: got %h want 0000000c", result); end
        tests++; if (zero !== 1'b0) begin failed++; $display("FAIL add_zero: got %b want 0", zero); end
        drive(1'b1, 3'b101, 32'd9, 32'd9);
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL sub_valid: got %b want 1", out_valid); end
        tests++; if (result !== 32'd0) begin failed++; $display("FAIL sub_result: got %h want 0", result); end
        tests++; if (zero !== 1'b1) begin failed++; $display("FAIL sub_zero: got %b want 1", zero); end
        drive(1'b1, 3'b101, 32'd3, 32'd5);
        @(negedge clk);
        tests++; if (result !== 32'hFFFF_FFFE) begin failed++; $display("FAIL sub_wrap: got %h want fffffffe", result); end
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_misc_ops();
        drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        tests++; if (result !== 32'd1) begin failed++; $display("FAIL slt_result: got %h want 1", result); end
        tests++; if (zero !== 1'b0) begin failed++; $display("FAIL slt_zero: got %b want 0", zero); end
        drive(1'b1, 3'b011, 32'd3, 32'd3);
        @(negedge clk);
        tests++; if (result !== 32'd0) begin failed++; $display("FAIL neq_eq_result: got %h want 0", result); end
        tests++; if (zero !== 1'b1) begin failed++; $display("FAIL neq_eq_zero: got %b want 1", zero); end
        drive(1'b1, 3'b011, 32'd3, 32'd4);
        @(negedge clk);
        tests++; if (result !== 32'd1) begin failed++; $display("FAIL neq_ne_result: got %h want 1", result); end
        drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        tests++; if (result !== 32'hFFFF_FFFF) begin failed++; $display("FAIL and_ones: got %h want ffffffff", result); end
        drive(1'b1, 3'b110, 32'd7, 32'd9);
        @(negedge clk);
        tests++; if (result !== 32'd0) begin failed++; $display("FAIL rsv110_result: got %h want 0", result); end
        tests++; if (zero !== 1'b1) begin failed++; $display("FAIL rsv110_zero: got %b want 1", zero); end
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL rsv110_valid: got %b want 1", out_valid); end
        drive(1'b1, 3'b111, 32'd1, 32'd1);
        @(negedge clk);
        tests++; if (zero !== 1'b1) begin failed++; $display("FAIL rsv111_zero: got %b want 1", zero); end
        drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        tests++; if (result !== 32'd0 || zero !== 1'b1) begin failed++; $display("FAIL add_wrap: got %h/%b want 0/1", result, zero); end
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_sll();
        int cyc;
        drive(1'b1, 3'b001, 32'd1, 32'd3);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
`ifdef ALU_FAST_SHIFT_EN
        tests++; if (out_valid !== 1'b1 || result !== 32'd8) begin failed++; $display("FAIL sll_fast: got %b/%h want 1/8", out_valid, result); end
`else
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL sll_busy_ready c%0d: got %b want 0", c, in_ready); end
            tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL sll_busy_valid c%0d: got %b want 0", c, out_valid); end
            @(negedge clk);
        end
        tests++; if (out_valid !== 1'b1 || result !== 32'd8) begin failed++; $display("FAIL sll_result: got %b/%h want 1/8", out_valid, result); end
`endif
        @(negedge clk);
        drive(1'b1, 3'b001, 32'hF000_000F, 32'hFFFF_FFE4);
        cyc = 0;
        do begin
            @(negedge clk);
            drive(1'b0, 3'b000, 32'd0, 32'd0);
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 10);
`ifdef ALU_FAST_SHIFT_EN
        tests++; if (cyc != 1) begin failed++; $display("FAIL sll4_latency: got %0d want 1", cyc); end
`else
        tests++; if (cyc != 5) begin failed++; $display("FAIL sll4_latency: got %0d want 5", cyc); end
`endif
        tests++; if (result !== 32'h0000_00F0) begin failed++; $display("FAIL sll4_result: got %h want 000000f0", result); end
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd0, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tests++; if (out_valid !== 1'b1 || zero !== 1'b1) begin failed++; $display("FAIL sll0: got %b/%b want 1/1", out_valid, zero); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'h0000_F0F0, 32'h0000_FF00);
        @(negedge clk);
        drive(1'b1, 3'b000, 32'd1, 32'd2);
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests++; if (out_valid !== 1'b1 || result !== 32'h0000_F000) begin failed++; $display("FAIL bp_hold c%0d: got %b/%h want 1/0000f000", c, out_valid, result); end
            tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tests++; if (out_valid !== 1'b1 || result !== 32'd3) begin failed++; $display("FAIL bp_next_op: got %b/%h want 1/3", out_valid, result); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 32'd1, 32'd20);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin failed++; $display("FAIL flush_clear: got %b/%h/%b want 0/0/0", out_valid, result, zero); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        tests++; if (seen != 0) begin failed++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end
        drive(1'b1, 3'b000, 32'd5, 32'd7);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        tests++; if (out_valid !== 1'b0 || result !== 32'd0) begin failed++; $display("FAIL flush_accept: got %b/%h want 0/0", out_valid, result); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL flush_accept_later: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'd5, 32'd7);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        drive(1'b1, 3'b001, 32'd1, 32'd20);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin failed++; $display("FAIL rst_mid: got %b/%h/%b want 0/0/0", out_valid, result, zero); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        tests++; if (seen != 0) begin failed++; $display("FAIL rst_mid_no_valid: got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        test_reset();
        test_add_sub();
        test_misc_ops();
        test_sll();
        test_backpressure();
        test_flush();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
